// File: rtl/sisc_core_mc.sv
// Multicycle reference execution engine: fetch/decode/execute FSM with a register file,
// a status register, conditional branches, halt and a wait-state-tolerant memory handshake.
module sisc_core_mc #(
  parameter int                ADDR_W   = 12,
  parameter int                NREG     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic [4:0]        psr_out,
  output logic              halted,
  output logic              illegal
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_e;
  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LD  = 4'h1, OP_STR = 4'h2, OP_BRA = 4'h3, OP_XOR = 4'h4,
    OP_ADD = 4'h5, OP_ROT = 4'h6, OP_SHF = 4'h7, OP_HLT = 4'h8, OP_CMP = 4'h9
  } op_e;

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [4:0]        psr;   // {C,P,E,Z,N}
  logic [31:0]       regs [NREG];

  logic [3:0]        op;
  logic [3:0]        cc;
  logic              src_type;
  logic [RW-1:0]     rs;
  logic [RW-1:0]     rd;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dest_addr;
  logic [31:0]       imm;
  logic [31:0]       d_val;
  logic [31:0]       s_val;
  logic [5:0]        cnt;
  logic              unused_dest_type;

  assign op               = ir[31:28];
  assign cc               = ir[27:24];
  assign src_type         = ir[27];
  assign unused_dest_type = ir[26];
  assign rs               = ir[12 +: RW];
  assign rd               = ir[0 +: RW];
  assign src_addr         = ir[12 +: ADDR_W];
  assign dest_addr        = ir[0 +: ADDR_W];
  assign imm              = {20'b0, ir[23:12]};
  assign cnt              = ir[17:12];
  assign d_val            = regs[rd];
  assign s_val            = src_type ? imm : regs[rs];

  assign pc_out  = pc;
  assign psr_out = psr;

  logic [31:0] res;
  logic        new_c;
  logic [5:0]  mag;
  logic        take_br;

  // Shifts run through a 33-bit window so the last bit shifted out lands in new_c;
  // a rotate right by n is the same as a rotate left by the low five count bits.
  always_comb begin
    res   = d_val;
    new_c = psr[4];
    mag   = '0;
    case (op)
      OP_XOR: res = d_val ^ s_val;
      OP_ADD: {new_c, res} = {1'b0, d_val} + {1'b0, s_val};
      OP_ROT: res = (d_val << cnt[4:0]) | (d_val >> (6'd32 - {1'b0, cnt[4:0]}));
      OP_SHF: begin
        if (cnt[5]) begin
          mag = -cnt;
          {res, new_c} = {d_val, 1'b0} >> mag;
        end else if (cnt != '0) begin
          {new_c, res} = {1'b0, d_val} << cnt;
        end
      end
      OP_CMP: res = ~s_val;
      default: ;
    endcase
  end

  always_comb begin
    case (cc)
      4'b0000: take_br = 1'b1;
      4'b0001: take_br = psr[4];
      4'b0010: take_br = psr[2];
      4'b0011: take_br = psr[3];
      4'b0100: take_br = psr[1];
      4'b0101: take_br = psr[0];
      default: take_br = 1'b0;
    endcase
  end

  // The next fetch request is raised on the way back to FETCH so a zero-wait
  // instruction costs three cycles; only the first fetch after reset pays a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      psr       <= '0;
      for (int unsigned i = 0; i < $unsigned(NREG); i++) regs[i] <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc + ADDR_W'(1);
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (op)
            OP_LD: begin
              if (src_type) begin
                state <= S_EXEC;
              end else begin
                state    <= S_MEM;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= src_addr;
              end
            end
            OP_STR: begin
              state     <= S_MEM;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= dest_addr;
              mem_wdata <= s_val;
            end
            OP_HLT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_NOP, OP_BRA, OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: state <= S_EXEC;
            default: begin
              illegal  <= 1'b1;
              state    <= S_FETCH;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end
          endcase
        end
        S_EXEC: begin
          case (op)
            OP_LD: regs[rd] <= imm;
            OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: begin
              regs[rd] <= res;
              psr      <= {new_c, ^res, ~res[0], res == '0, res[31]};
            end
            default: ;
          endcase
          if (op == OP_BRA && take_br) begin
            pc       <= dest_addr;
            mem_addr <= dest_addr;
          end else begin
            mem_addr <= pc;
          end
          mem_req <= 1'b1;
          mem_we  <= 1'b0;
          state   <= S_FETCH;
        end
        S_MEM: begin
          if (mem_ack) begin
            if (!mem_we) regs[rd] <= mem_rdata;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
